// File: rtl/ex_branch_resolve_unit.sv
// ex_branch_resolve_unit: EX-stage beq/bne resolver with target calculation, wrong-path flush FSM
// and a saturating taken-branch counter.
module ex_branch_resolve_unit #(
    parameter int DataBits    = 32,
    parameter int AddrBits    = 32,
    parameter int FlushCycles = 2,
    parameter int CountBits   = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 Stall,
    input  logic                 BranchValid,
    input  logic                 BranchNe,
    input  logic [DataBits-1:0]  OpA,
    input  logic [DataBits-1:0]  OpB,
    input  logic [AddrBits-1:0]  PcPlus4,
    input  logic [AddrBits-1:0]  Offset,
    output logic                 BeqTaken,
    output logic [AddrBits-1:0]  TargetPc,
    output logic                 PcRedirect,
    output logic                 FlushIfId,
    output logic                 FlushIdEx,
    output logic                 Busy,
    output logic [CountBits-1:0] TakenCount
);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t state, state_nx;
    logic [1:0] fcnt, fcnt_nx;
    logic beq_nx, redirect_nx, adv, taken;
    logic [AddrBits-1:0] target_nx;
    logic [CountBits-1:0] count_nx;
    assign adv = ClockEnable & Tick & ~Stall;
    assign taken = BranchValid & ((OpA == OpB) ^ BranchNe) & (state == IDLE);
    assign Busy = state != IDLE;
    assign FlushIfId = state == FLUSH;
    assign FlushIdEx = state == FLUSH;
    always_comb begin
        state_nx = state;
        fcnt_nx = fcnt;
        beq_nx = BeqTaken;
        redirect_nx = PcRedirect;
        target_nx = TargetPc;
        count_nx = TakenCount;
        if (adv && state == IDLE) begin
            beq_nx = taken;
            redirect_nx = taken;
            target_nx = BranchValid ? PcPlus4 + (Offset << 2) : TargetPc;
            state_nx = taken ? FLUSH : IDLE;
            fcnt_nx = taken ? 2'(FlushCycles) : fcnt;
            count_nx = (taken && !(&TakenCount)) ? TakenCount + 1'b1 : TakenCount;
        end else if (adv) begin
            beq_nx = 1'b0;
            redirect_nx = 1'b0;
            fcnt_nx = fcnt - 2'd1;
            state_nx = fcnt == 2'd1 ? IDLE : FLUSH;
        end
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            fcnt <= '0;
            BeqTaken <= 1'b0;
            PcRedirect <= 1'b0;
            TargetPc <= '0;
            TakenCount <= '0;
        end else begin
            state <= state_nx;
            fcnt <= fcnt_nx;
            BeqTaken <= beq_nx;
            PcRedirect <= redirect_nx;
            TargetPc <= target_nx;
            TakenCount <= count_nx;
        end
    end
endmodule

// File: tb/tb_ex_branch_resolve_unit.sv
// tb_ex_branch_resolve_unit: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the branch resolver.
module tb_ex_branch_resolve_unit;
    logic Clock, Reset, ClockEnable, Tick, Stall, BranchValid, BranchNe;
    logic [31:0] OpA, OpB, PcPlus4, Offset;
    logic BeqTaken, PcRedirect, FlushIfId, FlushIdEx, Busy;
    logic [31:0] TargetPc;
    logic [15:0] TakenCount;
    logic beq2, red2, fif2, fie2, busy2;
    logic [31:0] tgt2;
    logic [1:0] cnt2;
    int passed = 0, total = 0;
    int m_left, m_cnt, m_cnt2;
    bit m_beq, m_red;
    logic [31:0] m_tgt;

    ex_branch_resolve_unit dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick), .Stall(Stall),
        .BranchValid(BranchValid), .BranchNe(BranchNe), .OpA(OpA), .OpB(OpB),
        .PcPlus4(PcPlus4), .Offset(Offset), .BeqTaken(BeqTaken), .TargetPc(TargetPc),
        .PcRedirect(PcRedirect), .FlushIfId(FlushIfId), .FlushIdEx(FlushIdEx), .Busy(Busy),
        .TakenCount(TakenCount)
    );
    ex_branch_resolve_unit #(.CountBits(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick), .Stall(Stall),
        .BranchValid(BranchValid), .BranchNe(BranchNe), .OpA(OpA), .OpB(OpB),
        .PcPlus4(PcPlus4), .Offset(Offset), .BeqTaken(beq2), .TargetPc(tgt2),
        .PcRedirect(red2), .FlushIfId(fif2), .FlushIdEx(fie2), .Busy(busy2),
        .TakenCount(cnt2)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;

    task automatic model_clear();
        m_left = 0; m_cnt = 0; m_cnt2 = 0; m_beq = 0; m_red = 0; m_tgt = 0;
    endtask

    // Advance one clock and apply the architectural rules to the model for that edge.
    task automatic cycle();
        bit tk;
        @(posedge Clock);
        if (ClockEnable && Tick && !Stall) begin
            if (m_left == 0) begin
                tk = BranchValid && ((OpA == OpB) != BranchNe);
                m_beq = tk;
                m_red = tk;
                if (BranchValid) m_tgt = PcPlus4 + Offset * 4;
                if (tk) begin
                    m_left = 2;
                    m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
                    m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : m_cnt2;
                end
            end else begin
                m_beq = 0; m_red = 0; m_left--;
            end
        end
        #1;
    endtask

    task automatic set_branch(bit ne, logic [31:0] a, logic [31:0] b, logic [31:0] pc, logic [31:0] off);
        BranchValid = 1; BranchNe = ne; OpA = a; OpB = b; PcPlus4 = pc; Offset = off;
    endtask

    task automatic test_reset();
        Reset = 1; ClockEnable = 1; Tick = 1; Stall = 0; BranchValid = 0; BranchNe = 0;
        OpA = 0; OpB = 0; PcPlus4 = 0; Offset = 0;
        model_clear();
        #12;
        total++; if ({BeqTaken, PcRedirect, FlushIfId, FlushIdEx, Busy} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {BeqTaken, PcRedirect, FlushIfId, FlushIdEx, Busy}); else passed++;
        total++; if (TargetPc !== 32'h0) $display("FAIL reset_target got %h want 0", TargetPc); else passed++;
        total++; if (TakenCount !== 16'h0) $display("FAIL reset_count got %0d want 0", TakenCount); else passed++;
        Reset = 0;
    endtask

    task automatic test_taken_beq();
        set_branch(0, 5, 5, 32'h100, 3);
        cycle();
        BranchValid = 0;
        total++; if (BeqTaken !== 1'b1) $display("FAIL t1_beq got %b want 1", BeqTaken); else passed++;
        total++; if (TargetPc !== 32'h10C) $display("FAIL t1_target got %h want 10c", TargetPc); else passed++;
        total++; if (PcRedirect !== 1'b1) $display("FAIL t1_redirect got %b want 1", PcRedirect); else passed++;
        total++; if ({FlushIfId, FlushIdEx, Busy} !== 3'b111) $display("FAIL t1_flush1 got %b want 111", {FlushIfId, FlushIdEx, Busy}); else passed++;
        total++; if (TakenCount !== m_cnt[15:0]) $display("FAIL t1_count got %0d want %0d", TakenCount, m_cnt); else passed++;
        cycle();
        total++; if ({FlushIfId, FlushIdEx, BeqTaken, PcRedirect} !== 4'b1100) $display("FAIL t1_flush2 got %b want 1100", {FlushIfId, FlushIdEx, BeqTaken, PcRedirect}); else passed++;
        cycle();
        total++; if ({FlushIfId, FlushIdEx, Busy} !== 3'b000) $display("FAIL t1_idle got %b want 000", {FlushIfId, FlushIdEx, Busy}); else passed++;
    endtask

    task automatic test_not_taken();
        int c0 = m_cnt;
        set_branch(1, 7, 7, 32'h200, 5);
        cycle();
        BranchValid = 0;
        total++; if (BeqTaken !== 1'b0 || PcRedirect !== 1'b0) $display("FAIL t2_taken got %b%b want 00", BeqTaken, PcRedirect); else passed++;
        total++; if (TargetPc !== 32'h214) $display("FAIL t2_target got %h want 214", TargetPc); else passed++;
        total++; if (Busy !== 1'b0 || FlushIfId !== 1'b0) $display("FAIL t2_flush got %b%b want 00", Busy, FlushIfId); else passed++;
        total++; if (TakenCount !== 16'(c0)) $display("FAIL t2_count got %0d want %0d", TakenCount, c0); else passed++;
    endtask

    task automatic test_stall_in_flush();
        set_branch(0, 9, 9, 32'h400, 2);
        cycle();
        BranchValid = 0; Stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if ({Busy, FlushIfId, FlushIdEx, PcRedirect} !== 4'b1111) $display("FAIL t3_stall%0d got %b want 1111", i, {Busy, FlushIfId, FlushIdEx, PcRedirect}); else passed++;
        end
        Stall = 0;
        cycle();
        total++; if (Busy !== 1'b1 || PcRedirect !== 1'b0) $display("FAIL t3_adv1 got busy=%b red=%b want 1 0", Busy, PcRedirect); else passed++;
        cycle();
        total++; if (Busy !== 1'b0) $display("FAIL t3_adv2 got busy=%b want 0", Busy); else passed++;
        total++; if (TakenCount !== m_cnt[15:0]) $display("FAIL t3_count got %0d want %0d", TakenCount, m_cnt); else passed++;
    endtask

    task automatic test_ignore_in_flush();
        int c0;
        set_branch(0, 1, 1, 32'h800, 1);
        cycle();
        c0 = m_cnt;
        set_branch(0, 4, 4, 32'h1000, 8);
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++; if (PcRedirect !== 1'b0 || BeqTaken !== 1'b0) $display("FAIL t4_redirect%0d got %b%b want 00", i, PcRedirect, BeqTaken); else passed++;
            total++; if (TakenCount !== 16'(c0) || TargetPc !== 32'h804) $display("FAIL t4_state%0d got cnt=%0d tgt=%h want %0d 804", i, TakenCount, TargetPc, c0); else passed++;
        end
        BranchValid = 0;
    endtask

    task automatic test_reset_mid_flush();
        set_branch(0, 2, 2, 32'h40, 4);
        cycle();
        BranchValid = 0;
        #2 Reset = 1;
        model_clear();
        #1;
        total++; if ({BeqTaken, PcRedirect, FlushIfId, FlushIdEx, Busy} !== 5'b0) $display("FAIL t5_flags got %b want 00000", {BeqTaken, PcRedirect, FlushIfId, FlushIdEx, Busy}); else passed++;
        total++; if (TakenCount !== 16'h0 || TargetPc !== 32'h0) $display("FAIL t5_regs got cnt=%0d tgt=%h want 0 0", TakenCount, TargetPc); else passed++;
        Reset = 0;
        test_taken_beq();
    endtask

    task automatic test_saturate_wrap();
        Reset = 1; model_clear(); #2 Reset = 0;
        for (int i = 0; i < 5; i++) begin
            set_branch(0, i, i, 32'h0, i);
            cycle();
            BranchValid = 0;
            cycle();
            cycle();
        end
        total++; if (cnt2 !== 2'd3) $display("FAIL t6_sat got %0d want 3", cnt2); else passed++;
        total++; if (TakenCount !== 16'd5) $display("FAIL t6_count got %0d want 5", TakenCount); else passed++;
        set_branch(1, 3, 3, 32'hFFFF_FFFC, 1);
        cycle();
        BranchValid = 0;
        total++; if (TargetPc !== 32'h0 || tgt2 !== 32'h0) $display("FAIL t6_wrap got %h/%h want 0", TargetPc, tgt2); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ClockEnable = $urandom_range(0, 9) != 0;
            Tick = $urandom_range(0, 3) != 0;
            Stall = $urandom_range(0, 4) == 0;
            BranchValid = $urandom_range(0, 1) == 1;
            BranchNe = $urandom_range(0, 1) == 1;
            OpA = $urandom_range(0, 3);
            OpB = $urandom_range(0, 3);
            PcPlus4 = $urandom;
            Offset = $urandom;
            cycle();
            total++; if (BeqTaken !== m_beq || PcRedirect !== m_red) $display("FAIL rnd_taken@%0d got %b%b want %b%b", i, BeqTaken, PcRedirect, m_beq, m_red); else passed++;
            total++; if (TargetPc !== m_tgt) $display("FAIL rnd_target@%0d got %h want %h", i, TargetPc, m_tgt); else passed++;
            total++; if ({Busy, FlushIfId, FlushIdEx} !== {3{m_left != 0}}) $display("FAIL rnd_flush@%0d got %b want %0d left", i, {Busy, FlushIfId, FlushIdEx}, m_left); else passed++;
            total++; if (TakenCount !== m_cnt[15:0] || cnt2 !== m_cnt2[1:0]) $display("FAIL rnd_count@%0d got %0d/%0d want %0d/%0d", i, TakenCount, cnt2, m_cnt, m_cnt2); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_taken_beq();
        test_not_taken();
        test_stall_in_flush();
        test_ignore_in_flush();
        test_reset_mid_flush();
        test_saturate_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
